// File: rtl/piso_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : piso_tx_if
// Description : Word-load handshake bundle for the serial transmitter.
//               The source offers a word on in_data/in_valid and the
//               transmitter accepts it on a rising edge while in_ready is high.
// Revision    : 1.0 - initial release
// ============================================================================
interface piso_tx_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;

  // Word source side.
  modport master (
    output in_data,
    output in_valid,
    input  in_ready
  );

  // Transmitter side.
  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready
  );
endinterface
`default_nettype wire

// File: rtl/piso_tx.sv
`default_nettype none
// ============================================================================
// Module      : piso_tx
// Description : Parallel-in, serial-out transmitter. Loads a WIDTH-bit word
//               through a valid/ready handshake and shifts it out LSB-first,
//               one bit per clock with en=1. Pairs with a serial-in
//               right-shift receiver driven by d=sout, en=sout_valid.
// Revision    : 1.0 - initial release
// ============================================================================
module piso_tx #(
  parameter int WIDTH = 8
) (
  input  wire logic   clk,
  input  wire logic   rst,         // asynchronous, active-low
  piso_tx_if.slave    s_if,
  input  wire logic   en,
  output logic        sout,
  output logic        sout_valid,
  output logic        busy,
  output logic        done
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             done_q,  done_d;

  // State, shift register, bit counter and done pulse registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic: accept a word in IDLE, shift on enabled edges in SHIFT.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // The handshake completes whether or not en is high.
        if (s_if.in_valid) begin
          shreg_d = s_if.in_data;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (en) begin
          shreg_d = shreg_q >> 1;
          if (cnt_q == CNT_LAST) begin
            // Final bit consumed; clearing the counter keeps it in range
            // for widths that are not a power of two.
            cnt_d   = '0;
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs come straight from registers, except sout_valid which gates en.
  assign s_if.in_ready = (state_q == ST_IDLE);
  assign busy          = (state_q == ST_SHIFT);
  assign sout          = busy & shreg_q[0];
  assign sout_valid    = busy & en;
  assign done          = done_q;

endmodule
`default_nettype wire

// File: tb/tb_piso_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_piso_tx
// Description : Scoreboard bench for piso_tx. Stimulus pushes expected serial
//               bits, received words and control snapshots into queues; a
//               negedge monitor pops and compares them against the DUT and a
//               loopback serial-in right-shift receiver.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_piso_tx;

  localparam int WIDTH = 8;

  logic clk;
  logic rst;
  logic en;
  logic sout;
  logic sout_valid;
  logic busy;
  logic done;

  piso_tx_if #(.WIDTH(WIDTH)) bus ();

  piso_tx #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .s_if       (bus),
    .en         (en),
    .sout       (sout),
    .sout_valid (sout_valid),
    .busy       (busy),
    .done       (done)
  );

  // Loopback receiver: serial-in right-shift register fed by the transmitter.
  logic [WIDTH-1:0] rx_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rx_q <= '0;
    else if (sout_valid) rx_q <= {sout, rx_q[WIDTH-1:1]};
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard queues.
  logic             exp_bits [$];
  logic [WIDTH-1:0] exp_words[$];
  logic [4:0]       exp_ctl  [$];   // {busy, in_ready, sout_valid, done, sout}

  int   n_vec = 0;
  int   n_err = 0;
  logic end_req  = 1'b0;
  logic mon_done = 1'b0;

  // Monitor: all comparisons happen here, half a cycle after each active edge.
  initial begin
    logic [4:0]       c_got;
    logic [4:0]       c_exp;
    logic             b_exp;
    logic [WIDTH-1:0] w_exp;
    forever begin
      @(negedge clk);
      c_got = {busy, bus.in_ready, sout_valid, done, sout};
      if (exp_ctl.size() > 0) begin
        c_exp = exp_ctl.pop_front();
        n_vec++;
        if (c_got !== c_exp) begin
          n_err++;
          $display("FAIL ctl @%0t: got {busy,rdy,sv,done,sout}=%b expected %b", $time, c_got, c_exp);
        end
      end
      if (sout_valid !== 1'b0) begin
        n_vec++;
        if (exp_bits.size() == 0) begin
          n_err++;
          $display("FAIL bit @%0t: got sout_valid=%b sout=%b expected no bit", $time, sout_valid, sout);
        end else begin
          b_exp = exp_bits.pop_front();
          if (sout_valid !== 1'b1 || sout !== b_exp) begin
            n_err++;
            $display("FAIL bit @%0t: got sout=%b (valid=%b) expected %b", $time, sout, sout_valid, b_exp);
          end
        end
      end
      if (done !== 1'b0) begin
        n_vec++;
        if (exp_words.size() == 0) begin
          n_err++;
          $display("FAIL done @%0t: got done=%b expected no done pulse", $time, done);
        end else begin
          w_exp = exp_words.pop_front();
          if (done !== 1'b1 || rx_q !== w_exp) begin
            n_err++;
            $display("FAIL rx_word @%0t: got %h (done=%b) expected %h", $time, rx_q, done, w_exp);
          end
        end
      end
      if (end_req && !mon_done) begin
        n_vec++;
        if (exp_bits.size() != 0) begin
          n_err++;
          $display("FAIL bits_left: got %0d unsent bits expected 0", exp_bits.size());
        end
        n_vec++;
        if (exp_words.size() != 0) begin
          n_err++;
          $display("FAIL words_left: got %0d missing done pulses expected 0", exp_words.size());
        end
        n_vec++;
        if (exp_ctl.size() != 0) begin
          n_err++;
          $display("FAIL ctl_left: got %0d unchecked snapshots expected 0", exp_ctl.size());
        end
        mon_done = 1'b1;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_bits(input logic [WIDTH-1:0] w, input int nbits);
    for (int i = 0; i < nbits; i++) exp_bits.push_back(w[i]);
  endtask

  // Send one word with en held high; ends on the idle cycle after done.
  task automatic xmit(input logic [WIDTH-1:0] w);
    push_bits(w, WIDTH);
    exp_words.push_back(w);
    bus.in_data  = w;
    bus.in_valid = 1'b1;
    en           = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    repeat (WIDTH) tick();
    exp_ctl.push_back(5'b01010);
    tick();
  endtask

  initial begin
    rst          = 1'b0;
    en           = 1'b0;
    bus.in_data  = '0;
    bus.in_valid = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    exp_ctl.push_back(5'b01000);
    tick();

    // Test 1: A5 with en constant high.
    push_bits(8'hA5, WIDTH);
    exp_words.push_back(8'hA5);
    bus.in_data  = 8'hA5;
    bus.in_valid = 1'b1;
    en           = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    exp_ctl.push_back(5'b10101);         // first bit (1) visible, busy
    tick();
    exp_ctl.push_back(5'b10100);         // second bit (0)
    repeat (7) tick();
    exp_ctl.push_back(5'b01010);         // done cycle, idle
    tick();
    exp_ctl.push_back(5'b01000);         // done gone, en=1 in idle ignored
    tick();

    // Test 2: loopback words.
    xmit(8'h00);
    xmit(8'hFF);
    xmit(8'h3C);

    // Test 3: C3 with en stalling two cycles out of three.
    push_bits(8'hC3, WIDTH);
    exp_words.push_back(8'hC3);
    bus.in_data  = 8'hC3;
    bus.in_valid = 1'b1;
    en           = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    for (int k = 0; k < 24; k++) begin
      en = (k % 3 == 0);
      if (k == 1 || k == 2) exp_ctl.push_back(5'b10001);  // bit1=1 held
      if (k == 4 || k == 5) exp_ctl.push_back(5'b10000);  // bit2=0 held
      if (k == 22)          exp_ctl.push_back(5'b01010);  // done after 8th edge
      tick();
    end
    en = 1'b1;
    tick();

    // Test 4: F0 offered while busy with 0F must be dropped.
    push_bits(8'h0F, WIDTH);
    exp_words.push_back(8'h0F);
    bus.in_data  = 8'h0F;
    bus.in_valid = 1'b1;
    en           = 1'b1;
    tick();
    bus.in_data  = 8'hF0;
    bus.in_valid = 1'b1;
    repeat (3) tick();
    bus.in_valid = 1'b0;
    repeat (5) tick();
    exp_ctl.push_back(5'b01010);
    repeat (4) tick();

    // Test 5: in_valid held, 01 then 80 back to back.
    push_bits(8'h01, WIDTH);
    push_bits(8'h80, WIDTH);
    exp_words.push_back(8'h01);
    exp_words.push_back(8'h80);
    bus.in_data  = 8'h01;
    bus.in_valid = 1'b1;
    en           = 1'b1;
    tick();
    bus.in_data = 8'h80;
    repeat (WIDTH) tick();
    exp_ctl.push_back(5'b01010);         // single idle cycle between words
    tick();
    bus.in_valid = 1'b0;
    exp_ctl.push_back(5'b10100);         // 80 in flight, first bit 0
    repeat (WIDTH) tick();
    tick();

    // Test 6: asynchronous reset after the third bit of AA.
    push_bits(8'hAA, 3);
    bus.in_data  = 8'hAA;
    bus.in_valid = 1'b1;
    en           = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    repeat (3) tick();
    #1;
    rst = 1'b0;
    exp_ctl.push_back(5'b01000);
    tick();
    rst = 1'b1;
    exp_ctl.push_back(5'b01000);
    tick();
    xmit(8'h55);
    repeat (2) tick();

    end_req = 1'b1;
    repeat (2) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/piso_tx.md
Name: piso_tx

Overview:
Parallel-in, serial-out transmitter that pairs with the catalog's serial-in right-shift register (slr).
- Accepts a width-bit word through a valid/ready handshake.
- Shifts the word out LSB-first, one bit per enabled clock.
- Driving an slr of equal width with d=sout and en=sout_valid leaves exactly the loaded word in that receiver after width enabled bits.
- Sits at the transmit end of the catalog's serial link between datapath elements.

Parameters:
width, 8, word length in bits; legal range width >= 2.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-low reset
in_data  input  width  parallel word to transmit
in_valid  input  1  in_data is valid this cycle
in_ready  output  1  transmitter can accept a word this cycle
en  input  1  shift enable / bit-rate tick; one bit advances per cycle with en=1
sout  output  1  serial data bit
sout_valid  output  1  sout is a valid bit this cycle; drives receiver en
busy  output  1  word in flight
done  output  1  one-cycle pulse after the last bit of a word is sent

Behaviour:
Interface (already decided): one clock, clk; reset rst is asynchronous and active-low.

Reset (rst=0, asynchronous, any time including mid-word):
- State goes to IDLE.
- Shift register and bit counter clear to 0.
- done=0, busy=0, sout=0, sout_valid=0, in_ready=1.
- A word in flight is aborted silently; no done pulse is generated.

State machine, two states, IDLE and SHIFT.

IDLE:
- in_ready=1, busy=0, sout_valid=0, sout=0.
- A posedge with in_valid=1 performs the handshake: shreg<=in_data, cnt<=0, state<=SHIFT.
- The handshake completes regardless of en.

SHIFT:
- in_ready=0 and busy=1.
- sout=shreg[0], combinational from the register.
- sout_valid=en, combinational.
- Posedge with en=1: shreg<=shreg>>1 (zero fill), cnt<=cnt+1.
- Posedge with en=0: shreg and cnt hold. Stalls of any length are legal.
- Posedge with en=1 and cnt==width-1: final bit is consumed; state<=IDLE, done<=1.

done:
- Registered; high for exactly the one cycle after the final bit's enabled edge.
- Held 0 at all other times.

Counter:
- Width $clog2(width).
- Never exceeds width-1, so there is no wrap-around inside a word.
- Reloads to 0 on each accept.

Handshake rules:
- in_data and in_valid are ignored while in_ready=0. No buffering and no overrun: a word offered while busy is dropped unless the source holds in_valid until in_ready.
- in_valid may be held high continuously.

Throughput and latency:
- The cycle after done's triggering edge is IDLE, so the next word can be accepted there.
- Back-to-back sustained rate: one word per width+1 cycles with en=1 constant.
- Latency: the first bit appears on sout the cycle after the accepting edge.

Simultaneous events:
- en=1 during IDLE has no effect; sout_valid stays 0.
- in_valid=1 on the cycle done is high is accepted normally, since state is IDLE.

Timing: all outputs are glitch-free from registers, except sout_valid, which is a single AND of the state bit and en.

Test Plan:
1. Reset, load 8'hA5 with in_valid pulse, en=1 constant -> sout=1,0,1,0,0,1,0,1 with sout_valid=1 on 8 consecutive cycles, busy=1 throughout, done=1 on the following cycle only, then in_ready=1.
2. Loopback into an slr with width=8 (d=sout, en=sout_valid, rst shared) for words 8'h00, 8'hFF, 8'h3C -> receiver out equals the loaded word on the cycle done is high.
3. Load 8'hC3, en toggles 1,0,0,1,... -> bits advance only on en=1 edges, sout holds during gaps, and done arrives after exactly 8 enabled edges.
4. While busy with 8'h0F, present in_valid=1 with in_data=8'hF0 for 3 cycles, then drop it -> 8'hF0 is never transmitted; only 0F's bits (1,1,1,1,0,0,0,0) appear.
5. Hold in_valid=1 with 8'h01 then 8'h80, en=1 -> 16 bits 1,0,0,0,0,0,0,0,0,0,0,0,0,0,0,1 with one idle cycle (sout_valid=0) between the words, and two done pulses.
6. Assert rst=0 asynchronously (mid-cycle) after the 3rd bit of 8'hAA -> busy, sout_valid, and done go to 0 immediately, in_ready=1; no done pulse; the next word 8'h55 transmits correctly.
